cpld_ram_xbank: RTL and testbench
=================================

CPLD_RAM_XBANK -- requirements
Module: cpld_ram_xbank

Interface
REQ-001 SHALL have parameter BANK_BITS, default 3, 64K-bank select width; legal range 3..6, giving 512K..4M.
REQ-002 SHALL have parameter FILTER, default 2, the number of consecutive clk samples the I/O-write decode must stay true to be accepted; legal range 1..4.
REQ-003 SHALL have port clk, input, 1 bit: CPU clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port busreset_b, input, 1 bit: expansion-bus reset, active low, sampled synchronously.
REQ-006 SHALL have port adr, input, 8 bits: CPU address bits 15:8.
REQ-007 SHALL have ports iorq_b, mreq_b, wr_b and ramrd_b, each input, 1 bit, active-low CPU/bus strobes.
REQ-008 SHALL have port data, input, 8 bits: CPU data bus.
REQ-009 SHALL have port ramcs_b, output, 1 bit: expansion RAM chip select, active low.
REQ-010 SHALL have port ramdis, output, 1 bit: disables CPC internal RAM, active high.
REQ-011 SHALL have port ramadrhi, output, BANK_BITS+2 bits: RAM upper address, {bank, block}.
REQ-012 SHALL have port ramoe_b, output, 1 bit: RAM output enable.
REQ-013 SHALL have port ramwe_b, output, 1 bit: RAM write enable.
REQ-014 SHALL have port cfg_q, output, BANK_BITS+3 bits: active configuration, {bank, mode[2:0]}.
REQ-015 SHALL have port pend, output, 1 bit: a captured configuration is waiting to commit.

Function
REQ-016 Decode term SHALL be (adr[7]==0 && !iorq_b && !wr_b && data[7:6]==2'b11), evaluated each rising clk edge.
REQ-017 Captured bank SHALL be {~adr[BANK_BITS-4:0], data[5:3]}; extension bits are inverted so port 0x7Fxx selects extension 0.
REQ-018 When BANK_BITS==3, the bank SHALL be data[5:3] only.
REQ-019 Captured mode SHALL be data[2:0].
REQ-020 FSM states SHALL be IDLE, FILT, WAIT_END, PEND.
REQ-021 IDLE->FILT SHALL occur on the first edge the decode term is true; the filter counter is loaded with 1.
REQ-022 FILT SHALL increment the counter while the term is true and return to IDLE if the term goes false.
REQ-023 When the counter reaches FILTER, the FSM SHALL load the shadow register with {bank, mode} and go to WAIT_END.
REQ-024 When FILTER==1, shadow SHALL load on the IDLE->FILT edge itself and the FSM go straight to WAIT_END.
REQ-025 WAIT_END SHALL hold until iorq_b is sampled high, then go to PEND.
REQ-026 PEND SHALL commit shadow to cfg_q on the first edge with mreq_b sampled high, then go to IDLE; a bank switch never occurs mid memory cycle.
REQ-027 The decode term SHALL be ignored in WAIT_END and PEND; a following write is processed only after returning to IDLE.
REQ-028 pend SHALL be high exactly while the state is WAIT_END or PEND.
REQ-029 Mapping from cfg_q and adr[7:6] (CPU A15:A14), where hit means the expansion RAM is selected:
 - mode 000: never hit.
 - mode 001: hit when A15:A14==11, block 3.
 - mode 010: always hit, block = A15:A14.
 - mode 011: hit when A15:A14==11, block 3.
 - modes 100..111: hit when A15:A14==01, block = mode[1:0].
REQ-030 ramcs_b SHALL be !hit, ramdis SHALL be hit, and ramadrhi SHALL be {bank, block} when hit, else all zeros; these outputs are combinational from registered state.
REQ-031 ramoe_b SHALL equal ramrd_b, and ramwe_b SHALL equal (wr_b | mreq_b).
REQ-032 busreset_b sampled low SHALL synchronously clear cfg_q, shadow and the counter, force IDLE, and abort any pending commit.

Reset
REQ-033 While reset is high, asynchronously: cfg_q=0, shadow=0, counter=0, state=IDLE, pend=0, ramcs_b=1, ramdis=0, ramadrhi=0.
REQ-034 Reset asserted mid-capture or in PEND SHALL discard the shadow; no commit occurs after release.
REQ-035 The first decode SHALL be evaluated on the first rising clk edge after reset falls.

Verification
REQ-036 Test 1: BANK_BITS=3, FILTER=2, IO write 0x7F00<-0xC2 held 3 clks, then iorq_b high with mreq_b high -> cfg_q=6'b000010 one edge after PEND is entered, and A15:A14=10 gives ramadrhi=5'b00010 with ramcs_b=0.
REQ-037 Test 2: decode true for 1 clk only, with FILTER=2 -> FSM returns to IDLE, pend stays 0, cfg_q unchanged.
REQ-038 Test 3: BANK_BITS=5, write 0x7D00<-0xFC -> bank=5'b10111 (ext=~01), and A15:A14=01 gives ramadrhi=7'b1011100.
REQ-039 Test 4: mreq_b held low for 4 clks after iorq_b rises -> pend=1 throughout, and cfg_q updates on the first edge with mreq_b high.
REQ-040 Test 5: busreset_b pulsed low while in PEND -> cfg_q=0, pend=0 next edge; mode 000 gives ramcs_b=1 for all four A15:A14 values.
REQ-041 Test 6: reset asserted between clk edges in WAIT_END -> outputs match REQ-033 immediately, with no clk edge required.

Source files
------------

// File: rtl/cpld_ram_xbank.sv
// cpld_ram_xbank: CPC-style expansion RAM banking.
// An I/O write that the glitch filter accepts is captured into a shadow register.
// It is committed to the live configuration only after the I/O cycle has ended
// and no memory cycle is in progress. The live configuration maps CPU A15:A14
// onto the expansion RAM address lines.
module cpld_ram_xbank #(
  parameter int BANK_BITS = 3,
  parameter int FILTER    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 busreset_b,
  input  logic [7:0]           adr,
  input  logic                 iorq_b,
  input  logic                 mreq_b,
  input  logic                 wr_b,
  input  logic                 ramrd_b,
  input  logic [7:0]           data,
  output logic                 ramcs_b,
  output logic                 ramdis,
  output logic [BANK_BITS+1:0] ramadrhi,
  output logic                 ramoe_b,
  output logic                 ramwe_b,
  output logic [BANK_BITS+2:0] cfg_q,
  output logic                 pend
);

  typedef enum logic [1:0] {IDLE, FILT, WAIT_END, PEND} state_t;

  localparam logic [2:0] FILT_N = 3'(FILTER);

  state_t               r_state, w_next;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic [BANK_BITS+2:0] r_shadow, w_shadow_nxt;
  logic [BANK_BITS+2:0] r_cfg, w_cfg_nxt;
  logic                 w_term;
  logic [BANK_BITS-1:0] w_bank_cap;
  logic [BANK_BITS+2:0] w_cap;
  logic [2:0]           w_mode;
  logic [BANK_BITS-1:0] w_bank;
  logic [1:0]           w_a;
  logic                 w_hit;
  logic [1:0]           w_blk;
  logic                 w_unused;

  assign w_term = !adr[7] && !iorq_b && !wr_b && (data[7:6] == 2'b11);

  // The extension bank bits come from the high port byte. They are inverted,
  // so the traditional 0x7Fxx port selects extension 0.
  generate
    if (BANK_BITS == 3) begin : g_base
      assign w_bank_cap = data[5:3];
    end else begin : g_ext
      assign w_bank_cap = {~adr[BANK_BITS-4:0], data[5:3]};
    end
  endgenerate

  assign w_cap    = {w_bank_cap, data[2:0]};
  assign w_unused = &{1'b0, adr[6:0]};

  // Next-state logic: filter the decode, capture the shadow, wait for the I/O
  // cycle to end, then commit between memory cycles.
  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_cfg_nxt    = r_cfg;
    case (r_state)
      IDLE: begin
        if (w_term) begin
          w_cnt_nxt = 3'd1;
          if (FILT_N == 3'd1) begin
            w_shadow_nxt = w_cap;
            w_next       = WAIT_END;
          end else begin
            w_next = FILT;
          end
        end
      end
      FILT: begin
        if (!w_term) begin
          w_cnt_nxt = 3'd0;
          w_next    = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt + 3'd1 == FILT_N) begin
            w_shadow_nxt = w_cap;
            w_next       = WAIT_END;
          end
        end
      end
      WAIT_END: if (iorq_b) w_next = PEND;
      PEND: begin
        if (mreq_b) begin
          w_cfg_nxt = r_shadow;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // A bus reset wins over everything and drops any capture in flight.
    if (!busreset_b) begin
      w_next       = IDLE;
      w_cnt_nxt    = 3'd0;
      w_shadow_nxt = '0;
      w_cfg_nxt    = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_shadow <= '0;
      r_cfg    <= '0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_cfg    <= w_cfg_nxt;
    end
  end

  assign w_mode = r_cfg[2:0];
  assign w_bank = r_cfg[BANK_BITS+2:3];
  assign w_a    = adr[7:6];

  // Map the CPU 16K page onto an expansion block from the live mode.
  always_comb begin
    w_hit = 1'b0;
    w_blk = 2'd0;
    case (w_mode)
      3'b000: w_hit = 1'b0;
      3'b001, 3'b011: begin
        w_hit = (w_a == 2'b11);
        w_blk = 2'd3;
      end
      3'b010: begin
        w_hit = 1'b1;
        w_blk = w_a;
      end
      default: begin
        w_hit = (w_a == 2'b01);
        w_blk = w_mode[1:0];
      end
    endcase
  end

  assign ramcs_b  = !w_hit;
  assign ramdis   = w_hit;
  assign ramadrhi = w_hit ? {w_bank, w_blk} : '0;
  assign ramoe_b  = ramrd_b;
  assign ramwe_b  = wr_b | mreq_b;
  assign cfg_q    = r_cfg;
  assign pend     = (r_state == WAIT_END) || (r_state == PEND);

endmodule

// File: tb/tb_cpld_ram_xbank.sv
// Scoreboard bench for cpld_ram_xbank. Two instances share the inputs:
// one with BANK_BITS=5 and one with BANK_BITS=3, both with FILTER=2.
// Each driven cycle pushes the expected post-edge outputs. A monitor pops
// and compares one entry after every rising edge.
module tb_cpld_ram_xbank;
  localparam int FILTER = 2;

  logic clk = 1'b0;
  logic reset, busreset_b, iorq_b, mreq_b, wr_b, ramrd_b;
  logic [7:0] adr, data;

  logic cs5, dis5, oe5, we5, pend5;
  logic [6:0] hi5;
  logic [7:0] cfg5;
  logic cs3, dis3, oe3, we3, pend3;
  logic [4:0] hi3;
  logic [5:0] cfg3;

  cpld_ram_xbank #(.BANK_BITS(5), .FILTER(FILTER)) u_dut5 (
    .clk(clk), .reset(reset), .busreset_b(busreset_b), .adr(adr),
    .iorq_b(iorq_b), .mreq_b(mreq_b), .wr_b(wr_b), .ramrd_b(ramrd_b),
    .data(data), .ramcs_b(cs5), .ramdis(dis5), .ramadrhi(hi5),
    .ramoe_b(oe5), .ramwe_b(we5), .cfg_q(cfg5), .pend(pend5));

  cpld_ram_xbank #(.BANK_BITS(3), .FILTER(FILTER)) u_dut3 (
    .clk(clk), .reset(reset), .busreset_b(busreset_b), .adr(adr),
    .iorq_b(iorq_b), .mreq_b(mreq_b), .wr_b(wr_b), .ramrd_b(ramrd_b),
    .data(data), .ramcs_b(cs3), .ramdis(dis3), .ramadrhi(hi3),
    .ramoe_b(oe3), .ramwe_b(we3), .cfg_q(cfg3), .pend(pend3));

  always #5 clk = ~clk;

  typedef struct {
    logic       pend;
    logic [7:0] cfg5;
    logic [5:0] cfg3;
    logic       hit5, hit3;
    logic [6:0] hi5;
    logic [4:0] hi3;
    logic       oe, we;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: a transaction phase (0 = looking for a write,
  // 1 = waiting for the I/O cycle to end, 2 = waiting for a memory-idle edge),
  // plus a run length of consecutive decode edges.
  int         m_phase = 0;
  int         m_run   = 0;
  logic [7:0] m_cfg5 = '0, m_sh5 = '0;
  logic [5:0] m_cfg3 = '0, m_sh3 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mapf(input logic [2:0] mode, input logic [1:0] a,
                               output logic hit, output logic [1:0] blk);
    hit = 1'b0;
    blk = 2'd0;
    if (mode == 3'd0) hit = 1'b0;
    else if (mode == 3'd1 || mode == 3'd3) begin hit = (a == 2'd3); blk = 2'd3; end
    else if (mode == 3'd2) begin hit = 1'b1; blk = a; end
    else begin hit = (a == 2'd1); blk = mode[1:0]; end
  endfunction

  function automatic exp_t expect_now(input logic [7:0] a, input logic w, input logic mr, input logic rd);
    exp_t e;
    logic h;
    logic [1:0] b;
    e.pend = (m_phase != 0);
    e.cfg5 = m_cfg5;
    e.cfg3 = m_cfg3;
    mapf(m_cfg5[2:0], a[7:6], h, b);
    e.hit5 = h;
    e.hi5  = h ? {m_cfg5[7:3], b} : 7'd0;
    mapf(m_cfg3[2:0], a[7:6], h, b);
    e.hit3 = h;
    e.hi3  = h ? {m_cfg3[5:3], b} : 5'd0;
    e.oe   = rd;
    e.we   = w | mr;
    return e;
  endfunction

  // One bus cycle: drive at the falling edge, advance the model across the
  // coming rising edge, and queue what the outputs must be after it.
  task automatic cyc(input logic [7:0] a, input logic io, input logic mr, input logic w,
                     input logic rd, input logic [7:0] d, input logic br);
    logic term;
    @(negedge clk);
    adr = a; iorq_b = io; mreq_b = mr; wr_b = w; ramrd_b = rd; data = d; busreset_b = br;
    term = !a[7] && !io && !w && (d[7:6] == 2'b11);
    if (!br) begin
      m_phase = 0; m_run = 0; m_cfg5 = '0; m_sh5 = '0; m_cfg3 = '0; m_sh3 = '0;
    end else if (m_phase == 0) begin
      if (term) begin
        m_run++;
        if (m_run >= FILTER) begin
          m_sh5 = {~a[1:0], d[5:0]};
          m_sh3 = d[5:0];
          m_phase = 1;
          m_run = 0;
        end
      end else m_run = 0;
    end else if (m_phase == 1) begin
      if (io) m_phase = 2;
    end else begin
      if (mr) begin m_cfg5 = m_sh5; m_cfg3 = m_sh3; m_phase = 0; end
    end
    q.push_back(expect_now(a, w, mr, rd));
  endtask

  task automatic iow(input logic [7:0] a, input logic [7:0] d, input int hold);
    for (int i = 0; i < hold; i++) cyc(a, 1'b0, 1'b1, 1'b0, 1'b1, d, 1'b1);
  endtask

  task automatic idle(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(a, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
  endtask

  task automatic sweep();
    for (int i = 0; i < 4; i++) idle(8'(i << 6), 1);
  endtask

  // Monitor: one comparison set after each rising edge that has an entry queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pend5", 32'(pend5), 32'(e.pend));
        chk("pend3", 32'(pend3), 32'(e.pend));
        chk("cfg5", 32'(cfg5), 32'(e.cfg5));
        chk("cfg3", 32'(cfg3), 32'(e.cfg3));
        chk("cs5", 32'(cs5), 32'(!e.hit5));
        chk("dis5", 32'(dis5), 32'(e.hit5));
        chk("hi5", 32'(hi5), 32'(e.hi5));
        chk("cs3", 32'(cs3), 32'(!e.hit3));
        chk("dis3", 32'(dis3), 32'(e.hit3));
        chk("hi3", 32'(hi3), 32'(e.hi3));
        chk("oe", 32'({oe5, oe3}), 32'({e.oe, e.oe}));
        chk("we", 32'({we5, we3}), 32'({e.we, e.we}));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pend"}, 32'({pend5, pend3}), 32'd0);
    chk({tag, "_cfg5"}, 32'(cfg5), 32'd0);
    chk({tag, "_cfg3"}, 32'(cfg3), 32'd0);
    chk({tag, "_cs"}, 32'({cs5, cs3}), 32'd3);
    chk({tag, "_dis"}, 32'({dis5, dis3}), 32'd0);
    chk({tag, "_hi"}, 32'({hi5, hi3}), 32'd0);
  endtask

  initial begin
    int r, k;
    logic [7:0] a, d;
    reset = 1'b1; busreset_b = 1'b1; adr = 8'hC0; iorq_b = 1'b1; mreq_b = 1'b1;
    wr_b = 1'b1; ramrd_b = 1'b1; data = 8'h00;
    #3;
    chk_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Test 1: 0x7F00 <- 0xC2 held 3 clks, then commit, then sweep A15:A14.
    iow(8'h7F, 8'hC2, 3);
    idle(8'h80, 2);
    sweep();
    // Test 2: a one-edge decode is filtered out.
    iow(8'h7F, 8'hC5, 1);
    idle(8'h40, 3);
    // Test 3: extension bits from the port high byte.
    iow(8'h7D, 8'hFC, 2);
    idle(8'h40, 2);
    sweep();
    // Test 4: memory cycle in progress holds off the commit.
    iow(8'h7E, 8'hCA, 2);
    for (int i = 0; i < 4; i++) cyc(8'hC0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    idle(8'hC0, 2);
    // Test 5: bus reset while pending, then mode 000 never hits.
    iow(8'h7F, 8'hD3, 2);
    cyc(8'hC0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    cyc(8'hC0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    sweep();

    // Randomized transactions.
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {6'b011111, 2'($urandom)};
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {2'b11, 6'($urandom)};
      if (r < 6) begin
        iow(a, d, int'($urandom_range(1, 3)));
        k = int'($urandom_range(0, 3));
        for (int i = 0; i < k; i++)
          cyc(8'($urandom), 1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'b1);
        for (int i = 0; i < 2; i++)
          cyc(8'($urandom), 1'b1, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b1);
      end else if (r < 9) begin
        for (int i = 0; i < 3; i++)
          cyc(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), 1'b1);
      end else begin
        iow(a, d, 2);
        cyc(8'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
        cyc(8'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        idle(8'($urandom), 1);
      end
    end

    // Test 6: async reset while in WAIT_END with a hitting config live.
    iow(8'h7F, 8'hD2, 2);
    idle(8'hC0, 2);
    iow(8'h7F, 8'hDA, 2);
    cyc(8'hC0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
    @(negedge clk);
    #2;
    chk("pre_rst_pend", 32'({pend5, pend3}), 32'd3);
    reset = 1'b1;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    reset = 1'b0;
    m_phase = 0; m_run = 0; m_cfg5 = '0; m_sh5 = '0; m_cfg3 = '0; m_sh3 = '0;
    idle(8'hC0, 3);

    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
